// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences a single full_adder cell over WIDTH
// cycles (LSB first) to add two WIDTH-bit operands plus a carry-in.
// Requester handshake: start (accepted when not busy), busy, one-cycle done.

// Single-bit combinational full adder cell shared by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             creg_q, creg_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] psum_nx;
    logic             unused_psum_lsb;

    full_adder u_fa (
        .a  (opa_q[0]),
        .b  (opb_q[0]),
        .ci (creg_q),
        .s  (fa_sum),
        .co (fa_carry)
    );

    // Partial sum fills from the MSB side; after WIDTH shifts it is LSB-aligned.
    if (WIDTH == 1) begin : g_psum_w1
        assign psum_nx = fa_sum;
    end else begin : g_psum_wn
        assign psum_nx = {fa_sum, psum_q[WIDTH-1:1]};
    end

    // Bit 0 of the partial sum is always shifted out before it matters.
    assign unused_psum_lsb = psum_q[0];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            creg_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            creg_q  <= creg_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath control: load on accepted start, shift one bit per ADD cycle.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        creg_d  = creg_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    creg_d  = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                creg_d = fa_carry;
                psum_d = psum_nx;
                opa_d  = opa_q >> 1;
                opb_d  = opb_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = psum_nx;
                    cout_d  = fa_carry;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
